ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: the other direction of the PS/2 keyboard receive path fed by `clkps2`/`dataps2`. It sends one command byte (for example 0xED "set LEDs" or 0xFF "reset") from the FPGA to the keyboard, following the standard inhibit / request-to-send / device-clocked sequence, and reports the device acknowledge. It sits beside the PS/2 receiver in the top level and runs on the system pixel clock (`clk25m`). The PS/2 pins are open-drain: the block only ever pulls a line low or releases it.

---
 rtl/ps2_host_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   using the inhibit / request-to-send / device-clocked sequence and reports
//   the device acknowledge. Pins are open-drain: *_oe=1 pulls the line low.
//
// Ports
//   clk         system clock (CLKFREQ Hz)
//   rst         synchronous active-high reset
//   ps2clk_in   PS/2 clock pin level (asynchronous)
//   ps2data_in  PS/2 data pin level (asynchronous)
//   ps2clk_oe   1 pulls PS/2 clock low
//   ps2data_oe  1 pulls PS/2 data low
//   data        byte to send, captured when start is accepted
//   start       one-cycle request
//   busy        transfer in progress
//   done        one-cycle pulse, device acknowledged
//   error       one-cycle pulse, no acknowledge or timeout
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int CLKFREQ    = 25000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INHIBIT_CYCLES = CLKFREQ / 1000000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = CLKFREQ / 1000 * TIMEOUT_MS;
    localparam int ICW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ICW-1:0] IC_LAST = ICW'(INHIBIT_CYCLES - 1);
    localparam logic [ICW-1:0] IC_PRE  = ICW'(INHIBIT_CYCLES - 2);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_BITS,
        S_ACK,
        S_WAITIDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = clock pin, index 1 = data pin.
    // The filter output moves only when the current synchronized sample and
    // the three before it all agree, so pulses shorter than 4 cycles vanish.
    // ------------------------------------------------------------------
    logic [1:0]      w_pin;
    logic [1:0]      r_sync0, r_sync1;
    logic [1:0][2:0] r_hist;
    logic [1:0]      r_filt;
    logic            r_clk_filt_d;
    logic            w_clk_fall;

    assign w_pin = {ps2data_in, ps2clk_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0      <= '1;
            r_sync1      <= '1;
            r_hist       <= '1;
            r_filt       <= '1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_sync0 <= w_pin;
            r_sync1 <= r_sync0;
            for (int i = 0; i < 2; i++) begin
                r_hist[i] <= {r_hist[i][1:0], r_sync1[i]};
                if (r_hist[i] == {3{r_sync1[i]}})
                    r_filt[i] <= r_sync1[i];
            end
            r_clk_filt_d <= r_filt[0];
        end
    end

    assign w_clk_fall = r_clk_filt_d & ~r_filt[0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t          r_state, w_state;
    logic [ICW-1:0]  r_icnt, w_icnt;
    logic [TCW-1:0]  r_tmo, w_tmo;
    logic [9:0]      r_shift, w_shift;
    logic [3:0]      r_bitcnt, w_bitcnt;
    logic            r_data_oe, w_data_oe;
    logic            r_nack, w_nack;
    logic            r_done, w_done;
    logic            r_error, w_error;
    logic            w_busy;
    logic            w_timed;

    // busy also covers the done/error pulse cycle, so a start coinciding
    // with the pulse is ignored.
    assign w_busy  = (r_state != S_IDLE) | r_done | r_error;
    // Timeout window runs from clock release to the end of the transfer.
    assign w_timed = (r_state == S_RTS) || (r_state == S_BITS) ||
                     (r_state == S_ACK) || (r_state == S_WAITIDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_icnt    <= '0;
            r_tmo     <= '0;
            r_shift   <= '1;
            r_bitcnt  <= '0;
            r_data_oe <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_icnt    <= w_icnt;
            r_tmo     <= w_tmo;
            r_shift   <= w_shift;
            r_bitcnt  <= w_bitcnt;
            r_data_oe <= w_data_oe;
            r_nack    <= w_nack;
            r_done    <= w_done;
            r_error   <= w_error;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_icnt    = r_icnt;
        w_tmo     = w_timed ? TCW'(r_tmo + 1'b1) : '0;
        w_shift   = r_shift;
        w_bitcnt  = r_bitcnt;
        w_data_oe = r_data_oe;
        w_nack    = r_nack;
        w_done    = 1'b0;
        w_error   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_data_oe = 1'b0;
                if (start && !w_busy) begin
                    // stop, odd parity, data LSB first out of bit 0
                    w_shift  = {1'b1, ~^data, data};
                    w_icnt   = '0;
                    w_bitcnt = '0;
                    w_state  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_icnt = ICW'(r_icnt + 1'b1);
                // Start bit goes low on the last inhibit cycle so data is
                // already low when the clock is released.
                if (r_icnt == IC_PRE)
                    w_data_oe = 1'b1;
                if (r_icnt == IC_LAST)
                    w_state = S_RTS;
            end
            S_RTS: begin
                w_state = S_BITS;
            end
            S_BITS: begin
                if (w_clk_fall) begin
                    w_data_oe = ~r_shift[0];
                    w_shift   = {1'b1, r_shift[9:1]};
                    w_bitcnt  = r_bitcnt + 4'd1;
                    // 10th edge presents the stop bit (line released)
                    if (r_bitcnt == 4'd9)
                        w_state = S_ACK;
                end
            end
            S_ACK: begin
                if (w_clk_fall) begin
                    w_nack  = r_filt[1];
                    w_state = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                if (r_filt[0] && r_filt[1]) begin
                    w_done  = ~r_nack;
                    w_error = r_nack;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_data_oe = 1'b0;
                w_state   = S_IDLE;
            end
        endcase

        if (w_timed && (r_tmo == TO_LAST)) begin
            w_data_oe = 1'b0;
            w_done    = 1'b0;
            w_error   = 1'b1;
            w_state   = S_IDLE;
        end
    end

    assign ps2clk_oe  = (r_state == S_INHIBIT);
    assign ps2data_oe = r_data_oe;
    assign busy       = w_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with an open-drain bus and a simple
//   keyboard model that clocks bits in and drives (or withholds) the ack.
//   Scaled parameters: 1 MHz clk -> 100-cycle inhibit, 1000-cycle timeout.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int CLKFREQ    = 1000000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 1;
    localparam int IC   = 100;   // inhibit cycles at these parameters
    localparam int TMO  = 1000;  // timeout cycles at these parameters
    localparam int HALF = 20;    // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_oe, ps2data_oe, busy, done, error;

    // open-drain wired-AND with pull-ups
    assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data_in = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .CLKFREQ   (CLKFREQ),
        .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2clk_in (ps2clk_in),
        .ps2data_in(ps2data_in),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .data      (data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor
    int   n_done = 0, n_err = 0, n_both = 0, n_long = 0;
    logic done_q = 1'b0, err_q = 1'b0;
    always @(negedge clk) begin
        if (done)  n_done <= n_done + 1;
        if (error) n_err  <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
        if ((done && done_q) || (error && err_q)) n_long <= n_long + 1;
        done_q <= done;
        err_q  <= error;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ps2clk_oe;
            1:       return ps2data_oe;
            2:       return done;
            3:       return error;
            default: return busy;
        endcase
    endfunction

    // Called at a negedge; returns at the first negedge where sig(sel)==val.
    task automatic wait_for(input int sel, input logic val, input int lim,
                            output int t, output bit ok);
        int n;
        n = 0;
        while (sig(sel) !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        ok = (sig(sel) === val);
        t  = cyc;
    endtask

    // Keyboard model: samples data at release (start bit) and on each of
    // ten rising clock edges, then clocks the ack bit.
    task automatic dev_xfer(input bit ack, input int inj_k, input bit gl,
                            input int abort_k, output logic [10:0] s);
        s = '0;
        repeat (10) @(negedge clk);
        s[0] = ps2data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            for (int j = 0; j < HALF; j++) begin
                if (k == inj_k && j == 10) begin
                    data  = 8'h00;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            if (k == abort_k) begin
                dev_clk_low = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
            s[k] = ps2data_in;
            for (int j = 0; j < HALF; j++) begin
                dev_clk_low = gl && (j == 6 || j == 7);
                @(negedge clk);
            end
            dev_clk_low = 1'b0;
        end
        dev_data_low = ack;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input int inj,
                        input bit gl, input int abort_k, output logic [10:0] s);
        int t;
        bit ok;
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(0, 1'b0, IC + 20, t, ok);
        chk("clk_release", ok, 1);
        dev_xfer(ack, inj, gl, abort_k, s);
    endtask

    task automatic settle(input string tag);
        int t;
        bit ok;
        wait_for(4, 1'b0, 200, t, ok);
        chk(tag, ok, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [10:0] s;
        int t0, t1, t2;
        bit ok;
        int d0, e0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2clk_oe, 0);
        chk("rst_data_oe", ps2data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- acknowledged 0xED ----------------
        d0 = n_done; e0 = n_err;
        data  = 8'hED;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_clk_oe", ps2clk_oe, 1);
        chk("lat_data_oe", ps2data_oe, 0);
        t0 = cyc;
        wait_for(1, 1'b1, IC + 20, t1, ok);
        chk("start_bit_seen", ok, 1);
        chk("start_bit_delay", t1 - t0, IC - 1);
        chk("overlap_clk_oe", ps2clk_oe, 1);
        wait_for(0, 1'b0, 20, t2, ok);
        chk("release_seen", ok, 1);
        chk("release_delay", t2 - t1, 1);
        dev_xfer(1'b1, 0, 1'b0, 0, s);
        chk("ed_start", s[0], 0);
        chk("ed_byte", s[8:1], 8'hED);
        chk("ed_parity", s[9], 1);
        chk("ed_stop", s[10], 1);
        wait_for(2, 1'b1, 100, t0, ok);
        chk("ed_done_seen", ok, 1);
        // start in the pulse cycle must be ignored
        data  = 8'h12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pulse_start_busy", busy, 0);
        chk("pulse_start_clk_oe", ps2clk_oe, 0);
        chk("ed_done_cnt", n_done - d0, 1);
        chk("ed_err_cnt", n_err - e0, 0);

        // ---------------- no acknowledge 0xFF ----------------
        d0 = n_done; e0 = n_err;
        send(8'hFF, 1'b0, 0, 1'b0, 0, s);
        settle("ff_idle");
        chk("ff_byte", s[8:1], 8'hFF);
        chk("ff_parity", s[9], 1);
        chk("ff_done_cnt", n_done - d0, 0);
        chk("ff_err_cnt", n_err - e0, 1);
        chk("ff_clk_oe", ps2clk_oe, 0);
        chk("ff_data_oe", ps2data_oe, 0);

        // ---------------- start while busy ----------------
        d0 = n_done; e0 = n_err;
        send(8'hED, 1'b1, 3, 1'b0, 0, s);
        settle("busy_idle");
        chk("busy_byte", s[8:1], 8'hED);
        chk("busy_parity", s[9], 1);
        chk("busy_done_cnt", n_done - d0, 1);
        chk("busy_err_cnt", n_err - e0, 0);

        // ---------------- glitch rejection 0x96 ----------------
        d0 = n_done; e0 = n_err;
        send(8'h96, 1'b1, 0, 1'b1, 0, s);
        settle("gl_idle");
        chk("gl_byte", s[8:1], 8'h96);
        chk("gl_parity", s[9], 1);
        chk("gl_stop", s[10], 1);
        chk("gl_done_cnt", n_done - d0, 1);

        // ---------------- reset mid-transfer ----------------
        send(8'h00, 1'b1, 0, 1'b0, 4, s);
        chk("mid_data_oe", ps2data_oe, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_clk_oe", ps2clk_oe, 0);
        chk("mrst_data_oe", ps2data_oe, 0);
        chk("mrst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        d0 = n_done; e0 = n_err;
        send(8'hF4, 1'b1, 0, 1'b0, 0, s);
        settle("f4_idle");
        chk("f4_byte", s[8:1], 8'hF4);
        chk("f4_parity", s[9], 0);
        chk("f4_done_cnt", n_done - d0, 1);
        chk("f4_err_cnt", n_err - e0, 0);

        // ---------------- timeout ----------------
        d0 = n_done; e0 = n_err;
        data  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(0, 1'b0, IC + 20, t1, ok);
        chk("to_release", ok, 1);
        wait_for(3, 1'b1, TMO + 200, t2, ok);
        chk("to_error_seen", ok, 1);
        chk("to_delay", t2 - t1, TMO);
        chk("to_clk_oe", ps2clk_oe, 0);
        chk("to_data_oe", ps2data_oe, 0);
        repeat (5) @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_err_cnt", n_err - e0, 1);
        chk("to_done_cnt", n_done - d0, 0);

        // ---------------- pulse shape ----------------
        chk("pulse_both", n_both, 0);
        chk("pulse_long", n_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
